seq_multiply_param: RTL and testbench

Parametrised successor to the fixed 16-bit sequential multiplier. It computes an exact 2*WIDTH-bit product using a shift-add datapath that retires one multiplier bit per clock. Each operation selects signed or unsigned mode, and an in-flight operation can be aborted. It sits in the same arithmetic datapath and keeps the start/READY/product contract, so existing self-checking benches port with only WIDTH-dependent wait counts.

---
 rtl/seq_mult_pkg.sv | 11 +
 rtl/seq_multiply_param.sv | 107 ++++++++++
 tb/tb_seq_multiply_param.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the parametrised sequential shift-add multiplier.
package seq_mult_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage : seq_mult_pkg

// File: rtl/seq_multiply_param.sv
// Sequential shift-add multiplier: one multiplier bit per clock, exact 2*WIDTH-bit
// product, signed mode via magnitudes plus a sign fix folded into the last cycle.
module seq_multiply_param
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic               CLK,
   input  logic               RESET,
   input  logic               start,
   input  logic               is_signed,
   input  logic               abort,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] product,
   output logic               READY,
   output logic               done
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             r_state;
   logic [PW-1:0]      r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [PW-1:0]      r_acc;
   logic [CNT_W-1:0]   r_count;
   logic               r_neg;
   logic [PW-1:0]      r_product;
   logic               r_ready;
   logic               r_done;

   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [PW-1:0]      w_addend;
   logic [PW-1:0]      w_acc_sum;
   logic [PW-1:0]      w_result;
   logic               w_last;

   // The most-negative operand negates to itself, which read unsigned is its magnitude.
   assign w_a_neg   = is_signed & A[WIDTH-1];
   assign w_b_neg   = is_signed & B[WIDTH-1];
   assign w_a_mag   = w_a_neg ? (-A) : A;
   assign w_b_mag   = w_b_neg ? (-B) : B;

   assign w_addend  = r_mplier[0] ? r_mcand : '0;
   assign w_acc_sum = r_acc + w_addend;
   assign w_result  = r_neg ? (-w_acc_sum) : w_acc_sum;
   assign w_last    = (r_count == CNT_W'(1));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state   <= IDLE;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_count   <= '0;
         r_neg     <= 1'b0;
         r_product <= '0;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                  r_mplier <= w_b_mag;
                  r_acc    <= '0;
                  r_count  <= CNT_W'(WIDTH);
                  r_neg    <= w_a_neg ^ w_b_neg;
                  r_ready  <= 1'b0;
                  r_state  <= BUSY;
               end
            end
            BUSY: begin
               r_acc    <= w_acc_sum;
               r_mcand  <= {r_mcand[PW-2:0], 1'b0};
               r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
               r_count  <= r_count - CNT_W'(1);
               // Abort takes priority over a coincident completion.
               if (abort) begin
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end else if (w_last) begin
                  r_product <= w_result;
                  r_done    <= 1'b1;
                  r_ready   <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign product = r_product;
   assign READY   = r_ready;
   assign done    = r_done;

endmodule : seq_multiply_param

// File: tb/tb_seq_multiply_param.sv
// Bench for seq_multiply_param: directed WIDTH=16 table and protocol cases,
// plus randomized WIDTH=8 back-to-back regression against arithmetic products.
module tb_seq_multiply_param;

   logic        CLK = 1'b0;
   logic        RESET;

   logic        start16, signed16, abort16;
   logic [15:0] a16, b16;
   logic [31:0] p16;
   logic        rdy16, done16;

   logic        start8, signed8, abort8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        rdy8, done8;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic [31:0] exp;
      string       nm;
   } vec_t;

   vec_t vt[8];

   seq_multiply_param #(.WIDTH(16)) dut16 (
      .CLK(CLK), .RESET(RESET), .start(start16), .is_signed(signed16), .abort(abort16),
      .A(a16), .B(b16), .product(p16), .READY(rdy16), .done(done16)
   );

   seq_multiply_param #(.WIDTH(8)) dut8 (
      .CLK(CLK), .RESET(RESET), .start(start8), .is_signed(signed8), .abort(abort8),
      .A(a8), .B(b8), .product(p8), .READY(rdy8), .done(done8)
   );

   always #5 CLK = ~CLK;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
      longint p;
      if (s) p = longint'($signed(a)) * longint'($signed(b));
      else   p = longint'(a) * longint'(b);
      return p[31:0];
   endfunction

   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
      longint p;
      if (s) p = longint'($signed(a)) * longint'($signed(b));
      else   p = longint'(a) * longint'(b);
      return p[15:0];
   endfunction

   task automatic wait_ready16();
      int n;
      n = 0;
      while (rdy16 !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      if (rdy16 !== 1'b1) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_ready16: READY=%0b after %0d cycles, required 1", rdy16, n);
      end
   endtask

   // Start one 16-bit op, scramble A/B while busy, check exact 16-edge latency.
   task automatic run16(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [31:0] exp);
      int early;
      wait_ready16();
      a16 = a; b16 = b; signed16 = s; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      chk({nm, " ready_low"}, rdy16, 0);
      early = 0;
      for (int i = 1; i < 16; i++) begin
         a16 = 16'($urandom); b16 = 16'($urandom); signed16 = 1'($urandom);
         tick();
         if (done16 !== 1'b0 || rdy16 !== 1'b0) early++;
      end
      chk({nm, " no_early_done"}, early, 0);
      tick();
      chk({nm, " done"}, done16, 1);
      chk({nm, " ready"}, rdy16, 1);
      chk({nm, " product"}, p16, exp);
      tick();
      chk({nm, " done_pulse"}, done16, 0);
   endtask

   initial begin
      int        early;
      logic [7:0]  ra, rb;
      logic        rs;
      logic [15:0] rexp;
      logic [15:0] xa, xb;
      logic        xs;

      vt[0] = '{16'hFFF6, 16'h000A, 1'b1, 32'hFFFFFF9C, "s_m10_x_10"};
      vt[1] = '{16'hFFF6, 16'hFFF6, 1'b1, 32'h00000064, "s_m10_x_m10"};
      vt[2] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_min_x_min"};
      vt[3] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, "s_max_x_min"};
      vt[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u_ffff_sq"};
      vt[5] = '{16'h8000, 16'h0002, 1'b0, 32'h00010000, "u_8000_x_2"};
      vt[6] = '{16'h0000, 16'h8000, 1'b1, 32'h00000000, "s_zero"};
      vt[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "s_m1_x_m1"};

      RESET = 1'b0;
      start16 = 0; signed16 = 0; abort16 = 0; a16 = 0; b16 = 0;
      start8 = 0; signed8 = 0; abort8 = 0; a8 = 0; b8 = 0;
      tick();
      tick();
      chk("rst product", p16, 0);
      chk("rst ready", rdy16, 1);
      chk("rst done", done16, 0);
      RESET = 1'b1;
      early = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (p16 !== 32'h0 || rdy16 !== 1'b1 || done16 !== 1'b0) early++;
      end
      chk("idle_hold changes", early, 0);

      for (int i = 0; i < 8; i++)
         run16(vt[i].nm, vt[i].a, vt[i].b, vt[i].s, vt[i].exp);

      // Start held high through BUSY with changing operands.
      a16 = 16'd11; b16 = 16'd13; signed16 = 0; start16 = 1;
      tick();
      chk("hold_start ready_low", rdy16, 0);
      for (int i = 1; i < 16; i++) begin
         a16 = 16'($urandom); b16 = 16'($urandom);
         tick();
      end
      tick();
      start16 = 0;
      chk("hold_start done", done16, 1);
      chk("hold_start product", p16, 143);
      tick();
      chk("hold_start not_reaccepted", rdy16, 1);

      // Abort in cycle 8, prior result 100.
      run16("pre_abort", 16'hFFF6, 16'hFFF6, 1'b1, 32'd100);
      a16 = 16'd3; b16 = 16'd5; signed16 = 0; start16 = 1;
      tick();
      start16 = 0;
      for (int i = 1; i < 8; i++) tick();
      abort16 = 1;
      tick();
      abort16 = 0;
      chk("abort8 ready", rdy16, 1);
      chk("abort8 done", done16, 0);
      chk("abort8 product", p16, 100);
      early = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done16 !== 1'b0 || p16 !== 32'd100) early++;
      end
      chk("abort8 quiet_after", early, 0);

      // Abort coinciding with the completion edge.
      a16 = 16'd4; b16 = 16'd5; signed16 = 0; start16 = 1;
      tick();
      start16 = 0;
      for (int i = 1; i < 16; i++) tick();
      abort16 = 1;
      tick();
      abort16 = 0;
      chk("abort_last done", done16, 0);
      chk("abort_last ready", rdy16, 1);
      chk("abort_last product", p16, 100);

      // Abort plus start in IDLE: start accepted.
      a16 = 16'd6; b16 = 16'd7; signed16 = 0; start16 = 1; abort16 = 1;
      tick();
      start16 = 0; abort16 = 0;
      chk("abort_start accepted", rdy16, 0);
      for (int i = 1; i < 16; i++) tick();
      tick();
      chk("abort_start done", done16, 1);
      chk("abort_start product", p16, 42);

      // Reset in the middle of 7*9.
      a16 = 16'd7; b16 = 16'd9; signed16 = 0; start16 = 1;
      tick();
      start16 = 0;
      for (int i = 1; i < 5; i++) tick();
      RESET = 1'b0;
      #1;
      chk("midrst product", p16, 0);
      chk("midrst ready", rdy16, 1);
      chk("midrst done", done16, 0);
      tick();
      RESET = 1'b1;
      run16("after_rst", 16'd7, 16'd9, 1'b0, 32'd63);

      // Randomized 16-bit ops against the arithmetic model.
      for (int i = 0; i < 150; i++) begin
         xa = 16'($urandom); xb = 16'($urandom); xs = 1'($urandom);
         run16("rand16", xa, xb, xs, model16(xa, xb, xs));
      end

      // WIDTH=8 back-to-back randomized regression.
      for (int i = 0; i < 2000; i++) begin
         if (rdy8 !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rand8 op %0d: READY=%0b at issue, required 1", i, rdy8);
         end
         ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
         if (i % 16 == 0) begin
            ra = 8'h80;
            rs = 1'b1;
         end
         rexp = model8(ra, rb, rs);
         a8 = ra; b8 = rb; signed8 = rs; start8 = 1;
         tick();
         chk("rand8 ready_low", rdy8, 0);
         early = 0;
         for (int j = 1; j < 8; j++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); signed8 = 1'($urandom);
            start8 = 1'($urandom);
            tick();
            if (done8 !== 1'b0 || rdy8 !== 1'b0) early++;
         end
         chk("rand8 no_early_done", early, 0);
         start8 = 0;
         tick();
         chk("rand8 done", done8, 1);
         if (p8 !== rexp)
            $display("rand8 op %0d: A=%0h B=%0h signed=%0b", i, ra, rb, rs);
         chk("rand8 product", p8, rexp);
      end
      tick();
      chk("rand8 final done_pulse", done8, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_seq_multiply_param
